sequenciador_notas: RTL
=======================

// Module: sequenciador_notas
// PURPOSE
//  Parametrised note-sequence engine for the piano datapath: records, plays back and
//  trains multi-song note/duration sequences. Replaces the fixed 4-bit-note,
//  256-step memory + address/round counters with configurable widths and depth,
//  a per-song length table, loop playback and a step-training mode with error count.
//  Sits between the button encoder/metronome (inputs) and the LED decoder/buzzer.
// PARAMETERS
//  NOTE_W   4    note code width; code 0 = silence
//  DUR_W    4    duration width, in metronome ticks
//  DEPTH    256  entries per song (power of 2)
//  MUSICAS  16   number of songs (power of 2)
//  ERR_W    3    error counter width (saturating)
// PORTS
//  clock        in   1               system clock
//  reset        in   1               synchronous, active-high
//  tick         in   1               metronome pulse, 1 cycle wide
//  modo         in   2               00 idle, 01 grava, 10 toca, 11 treino; sampled at start
//  start        in   1               1-cycle command pulse
//  stop         in   1               1-cycle abort/finish pulse
//  repete       in   1               toca: wrap to entry 0 instead of finishing
//  musica       in   $clog2(MUSICAS) song select; sampled at start
//  nota_in      in   NOTE_W          encoded pressed note
//  nota_valida  in   1               1-cycle pulse: nota_in is a new event
//  nota_out     out  NOTE_W          note being played / expected
//  nota_out_ok  out  1               nota_out is valid
//  endereco     out  $clog2(DEPTH)   current entry index
//  ocupado      out  1               state != IDLE and != FIM
//  fim_musica   out  1               1-cycle pulse at song end / memory full
//  cheio        out  1               record stopped by full memory (held until next start)
//  acerto       out  1               treino: 1-cycle pulse, correct note
//  erro         out  1               treino: 1-cycle pulse, wrong note
//  erros        out  ERR_W           treino error count, saturates at all-ones
// BEHAVIOUR
//  - Storage: MUSICAS*DEPTH words of {nota,dur}, sync read (1-cycle), sync write;
//    length table comprimento[MUSICAS] of $clog2(DEPTH)+1 bits.
//  - Reset: all outputs 0, state IDLE, length table cleared (all songs empty);
//    note/dur memory is not cleared. Reset mid-operation aborts with no write.
//  - FSM: IDLE, GRAVA, BUSCA, TOCA, TREINO, FIM. start is honoured only in IDLE/FIM;
//    ignored otherwise. modo=00 with start: no action. stop in any busy state -> IDLE
//    next cycle (GRAVA flushes first, see below). start and stop together: stop wins.
//  - GRAVA: endereco=0, dur=0, cur=nota_in at start. Each tick: dur++ (saturates at
//    2^DUR_W-1). On nota_valida with nota_in != cur: write {cur, max(dur,1)} at endereco,
//    endereco++, cur<=nota_in, dur<=0. tick + nota_valida same cycle: write uses old dur,
//    new dur<=1. nota_valida with same code: ignored. stop: write pending entry if dur>0,
//    comprimento[musica]<=entries written, -> IDLE. Write to entry DEPTH-1:
//    comprimento=DEPTH, cheio=1, fim_musica pulse, -> FIM.
//  - BUSCA: 1 cycle read latency; nota_out_ok=0 during it.
//  - TOCA: nota_out=entry note, nota_out_ok=1; counts ticks; after dur ticks
//    endereco++ -> BUSCA. When endereco reaches comprimento: repete=1 -> endereco=0,
//    BUSCA; else fim_musica pulse -> FIM. comprimento=0: fim_musica 2 cycles after start.
//  - TREINO: erros<=0 at start. Entries with note 0 skipped (BUSCA, no wait). Waits for
//    nota_valida: match -> acerto pulse, advance; mismatch -> erro pulse, erros++
//    (saturating), stay. Ticks ignored. End as TOCA (repete ignored).
//  - FIM: nota_out_ok=0, endereco held, erros held; new start accepted.
//  - All pulse outputs registered, asserted exactly one cycle after the causing event.
// TESTING
//  1 reset then start toca song 3 -> fim_musica 2 cycles later, nota_out_ok stays 0.
//  2 grava song 1: nota 5 for 3 ticks, nota 7 for 2 ticks, stop -> comprimento=2,
//    memory {5,3},{7,2}; toca song 1 -> nota_out 5 for 3 ticks, 7 for 2, fim_musica.
//  3 same playback with repete=1 -> after {7,2} endereco wraps to 0, nota_out 5, no fim.
//  4 treino song 1: press 4 -> erro, erros=1; press 5 -> acerto, endereco=1; press 7
//    -> acerto, fim_musica; erros at 8 wrong presses saturates at 7 (ERR_W=3).
//  5 grava with DEPTH=4, 5 note changes -> cheio=1, comprimento=4, fim_musica once.
//  6 reset asserted mid-TOCA -> next cycle all outputs 0, IDLE, song 1 length 0.

Source files
------------

// File: rtl/sequenciador_notas.sv
// sequenciador_notas: records, plays back and trains multi-song note/duration
// sequences. Each song owns DEPTH words of {nota,dur}; a per-song length table
// tells playback/training where the song ends.
module sequenciador_notas #(
    parameter int NOTE_W  = 4,
    parameter int DUR_W   = 4,
    parameter int DEPTH   = 256,
    parameter int MUSICAS = 16,
    parameter int ERR_W   = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [1:0]                 modo,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       repete,
    input  logic [$clog2(MUSICAS)-1:0] musica,
    input  logic [NOTE_W-1:0]          nota_in,
    input  logic                       nota_valida,
    output logic [NOTE_W-1:0]          nota_out,
    output logic                       nota_out_ok,
    output logic [$clog2(DEPTH)-1:0]   endereco,
    output logic                       ocupado,
    output logic                       fim_musica,
    output logic                       cheio,
    output logic                       acerto,
    output logic                       erro,
    output logic [ERR_W-1:0]           erros
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MUSICAS);
    localparam int LW = AW + 1;
    localparam int WW = NOTE_W + DUR_W;
    localparam logic [AW-1:0]     A_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]     A_LAST   = {AW{1'b1}};
    localparam logic [LW-1:0]     L_ZERO   = {LW{1'b0}};
    localparam logic [LW-1:0]     L_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [LW-1:0]     L_FULL   = LW'(DEPTH);
    localparam logic [DUR_W-1:0]  D_ZERO   = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0]  D_ONE    = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0]  D_MAX    = {DUR_W{1'b1}};
    localparam logic [ERR_W-1:0]  E_ZERO   = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]  E_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  E_MAX    = {ERR_W{1'b1}};
    localparam logic [NOTE_W-1:0] N_SILENT = {NOTE_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRAVA  = 3'd1,
        S_BUSCA  = 3'd2,
        S_TOCA   = 3'd3,
        S_TREINO = 3'd4,
        S_FIM    = 3'd5
    } estado_t;

    estado_t           r_state;
    estado_t           w_next;
    logic [SW-1:0]     r_musica;
    logic [1:0]        r_modo;
    logic [AW-1:0]     r_end;
    logic [DUR_W-1:0]  r_dur;
    logic [NOTE_W-1:0] r_cur;
    logic [DUR_W-1:0]  r_cnt;
    logic [ERR_W-1:0]  r_erros;
    logic              r_cheio;
    logic [LW-1:0]     r_len [MUSICAS];
    logic [WW-1:0]     r_mem [MUSICAS*DEPTH];
    logic [WW-1:0]     r_rd_word;
    logic              r_ok, r_fim, r_acerto, r_erro, r_ocupado;
    logic              w_ok_n, w_fim_n, w_acerto_n, w_erro_n, w_ocupado_n;

    // Shared decode of the current step
    logic [SW+AW-1:0]  w_addr;
    logic [LW-1:0]     w_len, w_end_inc;
    logic [NOTE_W-1:0] w_rd_nota;
    logic [DUR_W-1:0]  w_rd_dur;
    logic              w_start_ok, w_last, w_dur_done, w_toca_adv;
    logic              w_tre_skip, w_tre_press, w_tre_hit, w_tre_miss, w_adv;
    logic              w_g_change, w_g_flush, w_we, w_full;
    logic [WW-1:0]     w_wdata;

    assign w_addr      = {r_musica, r_end};
    assign w_len       = r_len[r_musica];
    assign w_end_inc   = {1'b0, r_end} + L_ONE;
    assign w_last      = (w_end_inc == w_len);
    assign w_rd_nota   = r_rd_word[WW-1:DUR_W];
    assign w_rd_dur    = r_rd_word[DUR_W-1:0];
    assign w_start_ok  = ((r_state == S_IDLE) || (r_state == S_FIM)) && start && !stop
                         && (modo != 2'b00);
    // a step ends on the tick that completes its duration
    assign w_dur_done  = tick && (({1'b0, r_cnt} + {D_ZERO, 1'b1}) >= {1'b0, w_rd_dur});
    assign w_toca_adv  = (r_state == S_TOCA) && w_dur_done;
    assign w_tre_skip  = (r_state == S_TREINO) && (w_rd_nota == N_SILENT);
    assign w_tre_press = (r_state == S_TREINO) && !w_tre_skip && nota_valida;
    assign w_tre_hit   = w_tre_press && (nota_in == w_rd_nota);
    assign w_tre_miss  = w_tre_press && (nota_in != w_rd_nota);
    assign w_adv       = w_toca_adv || w_tre_skip || w_tre_hit;
    assign w_g_change  = (r_state == S_GRAVA) && nota_valida && (nota_in != r_cur);
    assign w_g_flush   = (r_state == S_GRAVA) && stop && (r_dur != D_ZERO);
    // reset in the same cycle must never leave a half-recorded entry behind
    assign w_we        = !reset && (w_g_flush || (w_g_change && !stop));
    assign w_full      = w_we && (r_end == A_LAST);
    assign w_wdata     = {r_cur, (r_dur == D_ZERO) ? D_ONE : r_dur};

    assign nota_out    = w_rd_nota;
    assign nota_out_ok = r_ok;
    assign endereco    = r_end;
    assign ocupado     = r_ocupado;
    assign fim_musica  = r_fim;
    assign cheio       = r_cheio;
    assign acerto      = r_acerto;
    assign erro        = r_erro;
    assign erros       = r_erros;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; stop always wins over any advance or start
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FIM: begin
                if (w_start_ok) w_next = (modo == 2'b01) ? S_GRAVA : S_BUSCA;
                else            w_next = r_state;
            end
            S_GRAVA: begin
                if (w_full)    w_next = S_FIM;
                else if (stop) w_next = S_IDLE;
                else           w_next = S_GRAVA;
            end
            S_BUSCA: begin
                if (stop)                 w_next = S_IDLE;
                else if (w_len == L_ZERO) w_next = S_FIM;
                else if (r_modo == 2'b10) w_next = S_TOCA;
                else                      w_next = S_TREINO;
            end
            S_TOCA: begin
                if (stop)            w_next = S_IDLE;
                else if (w_toca_adv) w_next = (w_last && !repete) ? S_FIM : S_BUSCA;
                else                 w_next = S_TOCA;
            end
            S_TREINO: begin
                if (stop)       w_next = S_IDLE;
                else if (w_adv) w_next = w_last ? S_FIM : S_BUSCA;
                else            w_next = S_TREINO;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered status/pulse outputs
    always_comb begin
        w_fim_n    = 1'b0;
        w_acerto_n = 1'b0;
        w_erro_n   = 1'b0;
        case (r_state)
            S_GRAVA:  w_fim_n = w_full;
            S_BUSCA:  w_fim_n = !stop && (w_len == L_ZERO);
            S_TOCA:   w_fim_n = !stop && w_toca_adv && w_last && !repete;
            S_TREINO: begin
                w_fim_n    = !stop && w_adv && w_last;
                w_acerto_n = !stop && w_tre_hit;
                w_erro_n   = !stop && w_tre_miss;
            end
            default: w_fim_n = 1'b0;
        endcase
        w_ok_n      = (w_next == S_TOCA) || (w_next == S_TREINO);
        w_ocupado_n = (w_next != S_IDLE) && (w_next != S_FIM);
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ok      <= 1'b0;
            r_fim     <= 1'b0;
            r_acerto  <= 1'b0;
            r_erro    <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_ok      <= w_ok_n;
            r_fim     <= w_fim_n;
            r_acerto  <= w_acerto_n;
            r_erro    <= w_erro_n;
            r_ocupado <= w_ocupado_n;
        end
    end

    // Datapath: command capture, recording counters, playback/training position
    always_ff @(posedge clock) begin
        if (reset) begin
            r_musica <= {SW{1'b0}};
            r_modo   <= 2'b00;
            r_end    <= {AW{1'b0}};
            r_dur    <= D_ZERO;
            r_cur    <= N_SILENT;
            r_cnt    <= D_ZERO;
            r_erros  <= E_ZERO;
            r_cheio  <= 1'b0;
            for (int i = 0; i < MUSICAS; i++) r_len[i] <= L_ZERO;
        end else begin
            case (r_state)
                S_IDLE, S_FIM: begin
                    if (w_start_ok) begin
                        r_musica <= musica;
                        r_modo   <= modo;
                        r_end    <= {AW{1'b0}};
                        r_dur    <= D_ZERO;
                        r_cur    <= nota_in;
                        r_cnt    <= D_ZERO;
                        r_cheio  <= 1'b0;
                        if (modo == 2'b11) r_erros <= E_ZERO;
                    end
                end
                S_GRAVA: begin
                    if (w_full) begin
                        r_len[r_musica] <= L_FULL;
                        r_cheio         <= 1'b1;
                    end else if (stop) begin
                        r_len[r_musica] <= {1'b0, r_end} + (w_g_flush ? L_ONE : L_ZERO);
                    end else if (w_g_change) begin
                        r_end <= r_end + A_ONE;
                        r_cur <= nota_in;
                        r_dur <= tick ? D_ONE : D_ZERO;
                    end else if (tick && (r_dur != D_MAX)) begin
                        r_dur <= r_dur + D_ONE;
                    end
                end
                S_BUSCA: r_cnt <= D_ZERO;
                S_TOCA: begin
                    if (!stop && w_toca_adv) begin
                        r_cnt <= D_ZERO;
                        if (!w_last)     r_end <= r_end + A_ONE;
                        else if (repete) r_end <= {AW{1'b0}};
                    end else if (!stop && tick) begin
                        r_cnt <= r_cnt + D_ONE;
                    end
                end
                S_TREINO: begin
                    if (!stop) begin
                        if (w_tre_miss && (r_erros != E_MAX)) r_erros <= r_erros + E_ONE;
                        if (w_adv && !w_last) r_end <= r_end + A_ONE;
                    end
                end
                default: r_cnt <= D_ZERO;
            endcase
        end
    end

    // Note/duration storage write port (not cleared by reset)
    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_addr] <= w_wdata;
    end

    // Synchronous read of the current entry while fetching
    always_ff @(posedge clock) begin
        if (reset)                   r_rd_word <= {WW{1'b0}};
        else if (r_state == S_BUSCA) r_rd_word <= r_mem[w_addr];
    end
endmodule
